// File: rtl/cirno9_axil_mst_pkg.sv
// Shared types for the cirno9 LSU-to-AXI4-Lite master bridge: response codes,
// FSM state encoding and the response-error helper.
package cirno9_axil_mst_pkg;

  typedef enum logic [1:0] {
    CIRNO9_AXIL_RESP_OKAY   = 2'b00,
    CIRNO9_AXIL_RESP_EXOKAY = 2'b01,
    CIRNO9_AXIL_RESP_SLVERR = 2'b10,
    CIRNO9_AXIL_RESP_DECERR = 2'b11
  } axil_resp_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WADR = 3'd1,
    ST_WRSP = 3'd2,
    ST_RADR = 3'd3,
    ST_RRSP = 3'd4,
    ST_DONE = 3'd5
  } axil_state_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != CIRNO9_AXIL_RESP_OKAY;
  endfunction

endpackage

// File: rtl/cirno9_axil_mst.sv
// LSU request port to AXI4-Lite single-beat master, one transaction outstanding.
// CIRNO9_AXIL_POSTWR_EN: posted writes with a sticky B-channel error flag.
module cirno9_axil_mst
  import cirno9_axil_mst_pkg::*;
#(
  parameter logic [2:0] AXIL_PROT = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs_ls4axim_val,
  output logic        hs_axim4ls_rdy,
  input  logic [31:0] i_axim_adr,
  input  logic [31:0] i_axim_wdat,
  input  logic [3:0]  i_axim_wen,
  input  logic        i_axim_ren,
  output logic [31:0] o_axim_rdat,
  output logic        o_axim_err,
  output logic        o_bus_err_sticky,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awprot,
  output logic        m_wvalid,
  input  logic        m_wready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_bvalid,
  output logic        m_bready,
  input  logic [1:0]  m_bresp,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arprot,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp
);

  axil_state_e r_state;
  logic [31:0] r_adr, r_wdata, r_rdat;
  logic [3:0]  r_wstrb;
  logic        r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic        r_rdy, r_err;
  logic [31:0] w_adr_al;
  logic        w_aw_done, w_w_done, w_accept;

  assign w_adr_al  = i_axim_adr & 32'hFFFF_FFFC;
  assign w_aw_done = ~r_awvalid | m_awready;
  assign w_w_done  = ~r_wvalid | m_wready;

`ifdef CIRNO9_AXIL_POSTWR_EN
  logic r_pend_b, r_sticky;
  logic w_b_hs;
  assign w_b_hs   = m_bvalid & r_bready;
  // A B handshake in the accept cycle already counts as drained.
  assign w_accept = hs_ls4axim_val & (~r_pend_b | w_b_hs);
  assign o_bus_err_sticky = r_sticky;
`else
  assign w_accept = hs_ls4axim_val;
  assign o_bus_err_sticky = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_adr     <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdat    <= '0;
      r_err     <= 1'b0;
      r_rdy     <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
`ifdef CIRNO9_AXIL_POSTWR_EN
      r_pend_b  <= 1'b0;
      r_sticky  <= 1'b0;
`endif
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (i_axim_wen != '0) begin
              r_adr     <= w_adr_al;
              r_wdata   <= i_axim_wdat;
              r_wstrb   <= i_axim_wen;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_WADR;
            end else if (i_axim_ren) begin
              r_adr     <= w_adr_al;
              r_arvalid <= 1'b1;
              r_state   <= ST_RADR;
            end else begin
              r_rdat  <= '0;
              r_err   <= 1'b0;
              r_rdy   <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_WADR: begin
          if (m_awready) r_awvalid <= 1'b0;
          if (m_wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
`ifdef CIRNO9_AXIL_POSTWR_EN
            r_err    <= 1'b0;
            r_rdy    <= 1'b1;
            r_pend_b <= 1'b1;
            r_bready <= 1'b1;
            r_state  <= ST_DONE;
`else
            r_bready <= 1'b1;
            r_state  <= ST_WRSP;
`endif
          end
        end
        ST_WRSP: begin
          if (m_bvalid) begin
            r_bready <= 1'b0;
            r_err    <= resp_is_err(m_bresp);
            r_rdy    <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        ST_RADR: begin
          if (m_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RRSP;
          end
        end
        ST_RRSP: begin
          if (m_rvalid) begin
            r_rready <= 1'b0;
            r_rdat   <= m_rdata;
            r_err    <= resp_is_err(m_rresp);
            r_rdy    <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
`ifdef CIRNO9_AXIL_POSTWR_EN
      if (r_pend_b && m_bvalid) begin
        r_pend_b <= 1'b0;
        r_bready <= 1'b0;
        if (resp_is_err(m_bresp)) r_sticky <= 1'b1;
      end
`endif
    end
  end

  assign hs_axim4ls_rdy = r_rdy;
  assign o_axim_rdat    = r_rdat;
  assign o_axim_err     = r_err;
  assign m_awvalid      = r_awvalid;
  assign m_awaddr       = r_adr;
  assign m_awprot       = AXIL_PROT;
  assign m_wvalid       = r_wvalid;
  assign m_wdata        = r_wdata;
  assign m_wstrb        = r_wstrb;
  assign m_bready       = r_bready;
  assign m_arvalid      = r_arvalid;
  assign m_araddr       = r_adr;
  assign m_arprot       = AXIL_PROT;
  assign m_rready       = r_rready;

endmodule

// File: tb/tb_cirno9_axil_mst.sv
// Bench for cirno9_axil_mst: reactive AXI4-Lite slave with programmable delays
// and a transaction-level reference model of the LSU-visible results.
module tb_cirno9_axil_mst;
  logic        clk = 1'b0;
  logic        rst;
  logic        hs_ls4axim_val, hs_axim4ls_rdy;
  logic [31:0] i_axim_adr, i_axim_wdat, o_axim_rdat;
  logic [3:0]  i_axim_wen;
  logic        i_axim_ren, o_axim_err, o_bus_err_sticky;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cirno9_axil_mst #(.AXIL_PROT(3'b101)) dut (
    .clk(clk), .rst(rst),
    .hs_ls4axim_val(hs_ls4axim_val), .hs_axim4ls_rdy(hs_axim4ls_rdy),
    .i_axim_adr(i_axim_adr), .i_axim_wdat(i_axim_wdat), .i_axim_wen(i_axim_wen),
    .i_axim_ren(i_axim_ren), .o_axim_rdat(o_axim_rdat), .o_axim_err(o_axim_err),
    .o_bus_err_sticky(o_bus_err_sticky),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  // Slave configuration, written only by the test tasks.
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  bresp_v = 2'b00, rresp_v = 2'b00;
  logic [31:0] rdata_v = '0;

  // Slave state and statistics, written only by the slave process.
  int aw_wait, w_wait, ar_wait, b_wait, r_wait;
  bit aw_got, w_got, b_pend, r_pend;
  int awv_tot = 0, wv_tot = 0, anyv_tot = 0, ar_during_b = 0;
  int aw_hs_tot = 0, w_hs_tot = 0, ar_hs_tot = 0, b_hs_tot = 0, r_hs_tot = 0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  logic [3:0]  cap_wstrb = '0;
  logic [2:0]  cap_awprot = '0, cap_arprot = '0;

  // Slave acts at the falling edge; a valid/ready pair seen here completes at the next rising edge.
  initial begin
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = '0;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      end else begin
        if (m_arvalid && b_pend) ar_during_b++;
        if (m_awvalid || m_wvalid || m_arvalid) anyv_tot++;
        if (b_pend) begin
          if (!m_bvalid) begin
            if (b_wait >= b_dly) begin m_bvalid = 1; m_bresp = bresp_v; end
            else b_wait++;
          end
          if (m_bvalid && m_bready) begin b_pend = 0; b_hs_tot++; end
        end else m_bvalid = 0;
        if (r_pend) begin
          if (!m_rvalid) begin
            if (r_wait >= r_dly) begin m_rvalid = 1; m_rdata = rdata_v; m_rresp = rresp_v; end
            else r_wait++;
          end
          if (m_rvalid && m_rready) begin r_pend = 0; r_hs_tot++; end
        end else m_rvalid = 0;
        if (m_arvalid) begin
          if (ar_wait >= ar_dly) begin
            m_arready = 1; cap_araddr = m_araddr; cap_arprot = m_arprot;
            ar_hs_tot++; r_pend = 1; r_wait = 0; ar_wait = 0;
          end else begin m_arready = 0; ar_wait++; end
        end else begin m_arready = 0; ar_wait = 0; end
        if (m_awvalid) begin
          awv_tot++;
          if (aw_wait >= aw_dly) begin
            m_awready = 1; cap_awaddr = m_awaddr; cap_awprot = m_awprot;
            aw_hs_tot++; aw_got = 1; aw_wait = 0;
          end else begin m_awready = 0; aw_wait++; end
        end else begin m_awready = 0; aw_wait = 0; end
        if (m_wvalid) begin
          wv_tot++;
          if (w_wait >= w_dly) begin
            m_wready = 1; cap_wdata = m_wdata; cap_wstrb = m_wstrb;
            w_hs_tot++; w_got = 1; w_wait = 0;
          end else begin m_wready = 0; w_wait++; end
        end else begin m_wready = 0; w_wait = 0; end
        if (aw_got && w_got) begin b_pend = 1; b_wait = 0; aw_got = 0; w_got = 0; end
      end
    end
  end

  // LSU-side driver: call at a falling edge; returns at a falling edge one cycle after rdy.
  task automatic do_req(input logic [31:0] adr, input logic [31:0] wdat, input logic [3:0] wen,
                        input logic ren, output int cyc, output logic [31:0] rdat,
                        output logic err, output logic pulse_ok);
    hs_ls4axim_val = 1; i_axim_adr = adr; i_axim_wdat = wdat; i_axim_wen = wen; i_axim_ren = ren;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!hs_axim4ls_rdy && cyc < 300);
    rdat = o_axim_rdat; err = o_axim_err;
    hs_ls4axim_val = 0; i_axim_wen = '0; i_axim_ren = 0;
    @(negedge clk);
    pulse_ok = !hs_axim4ls_rdy;
  endtask

  task automatic test_reset();
    hs_ls4axim_val = 0; i_axim_adr = '0; i_axim_wdat = '0; i_axim_wen = '0; i_axim_ren = 0;
    rst = 1;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({m_awvalid, m_wvalid, m_arvalid} !== 3'b000) begin
      errors++; $display("FAIL reset_valids got %b want 000", {m_awvalid, m_wvalid, m_arvalid});
    end
    checks++;
    if ({m_bready, m_rready, hs_axim4ls_rdy} !== 3'b000) begin
      errors++; $display("FAIL reset_readys got %b want 000", {m_bready, m_rready, hs_axim4ls_rdy});
    end
    checks++;
    if (o_axim_rdat !== 32'h0) begin errors++; $display("FAIL reset_rdat got %h want 0", o_axim_rdat); end
    checks++;
    if ({o_axim_err, o_bus_err_sticky} !== 2'b00) begin
      errors++; $display("FAIL reset_err got %b want 00", {o_axim_err, o_bus_err_sticky});
    end
    rst = 0;
  endtask

  task automatic test_read();
    int cyc; logic [31:0] rdat; logic err, pok;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    rdata_v = 32'h1234_5678; rresp_v = 2'b00;
    do_req(32'h4000_0006, 32'h0, 4'h0, 1'b1, cyc, rdat, err, pok);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL read_latency got %0d want 3", cyc); end
    checks++; if (rdat !== 32'h1234_5678) begin errors++; $display("FAIL read_rdat got %h want 12345678", rdat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL read_err got %b want 0", err); end
    checks++; if (cap_araddr !== 32'h4000_0004) begin errors++; $display("FAIL read_araddr got %h want 40000004", cap_araddr); end
    checks++; if (cap_arprot !== 3'b101) begin errors++; $display("FAIL read_arprot got %b want 101", cap_arprot); end
    checks++; if (pok !== 1'b1) begin errors++; $display("FAIL read_rdy_pulse got held want single"); end
  endtask

  task automatic test_write();
    int cyc, awv0, wv0, bhs0, want_cyc; logic [31:0] rdat; logic err, pok;
    aw_dly = 3; w_dly = 0; b_dly = 0; bresp_v = 2'b00;
    awv0 = awv_tot; wv0 = wv_tot; bhs0 = b_hs_tot;
`ifdef CIRNO9_AXIL_POSTWR_EN
    want_cyc = 5;
`else
    want_cyc = 6;
`endif
    do_req(32'h0000_2013, 32'h0000_BEEF, 4'b0011, 1'b0, cyc, rdat, err, pok);
    checks++; if (awv_tot - awv0 !== 4) begin errors++; $display("FAIL write_awvalid_cycles got %0d want 4", awv_tot - awv0); end
    checks++; if (wv_tot - wv0 !== 1) begin errors++; $display("FAIL write_wvalid_cycles got %0d want 1", wv_tot - wv0); end
    checks++; if (cap_wstrb !== 4'b0011) begin errors++; $display("FAIL write_wstrb got %b want 0011", cap_wstrb); end
    checks++; if (cap_wdata !== 32'h0000_BEEF) begin errors++; $display("FAIL write_wdata got %h want 0000beef", cap_wdata); end
    checks++; if (cap_awaddr !== 32'h0000_2010) begin errors++; $display("FAIL write_awaddr got %h want 00002010", cap_awaddr); end
    checks++; if (cap_awprot !== 3'b101) begin errors++; $display("FAIL write_awprot got %b want 101", cap_awprot); end
    checks++; if (cyc !== want_cyc) begin errors++; $display("FAIL write_latency got %0d want %0d", cyc, want_cyc); end
    checks++; if (b_hs_tot - bhs0 !== 1) begin errors++; $display("FAIL write_b_count got %0d want 1", b_hs_tot - bhs0); end
    checks++; if ({err, pok} !== 2'b01) begin errors++; $display("FAIL write_err_pulse got %b want 01", {err, pok}); end
    aw_dly = 0;
  endtask

  task automatic test_rd_err();
    int cyc; logic [31:0] rdat; logic err, pok;
    rdata_v = 32'hCAFE_0001; rresp_v = 2'b10;
    do_req(32'h0000_0100, 32'h0, 4'h0, 1'b1, cyc, rdat, err, pok);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL rd_slverr_err got %b want 1", err); end
    checks++; if (rdat !== 32'hCAFE_0001) begin errors++; $display("FAIL rd_slverr_rdat got %h want cafe0001", rdat); end
    rdata_v = 32'h0BAD_F00D; rresp_v = 2'b00;
    do_req(32'h0000_0104, 32'h0, 4'h0, 1'b1, cyc, rdat, err, pok);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd_okay_err got %b want 0", err); end
    checks++; if (rdat !== 32'h0BAD_F00D) begin errors++; $display("FAIL rd_okay_rdat got %h want 0badf00d", rdat); end
  endtask

  task automatic test_null();
    int cyc, any0; logic [31:0] rdat; logic err, pok;
    any0 = anyv_tot;
    do_req(32'hFFFF_FFFF, 32'h1111_1111, 4'h0, 1'b0, cyc, rdat, err, pok);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL null_latency got %0d want 1", cyc); end
    checks++; if ({rdat, err} !== 33'h0) begin errors++; $display("FAIL null_result got %h/%b want 0/0", rdat, err); end
    checks++; if (anyv_tot !== any0) begin errors++; $display("FAIL null_bus_traffic got %0d want 0", anyv_tot - any0); end
    checks++; if (pok !== 1'b1) begin errors++; $display("FAIL null_rdy_pulse got held want single"); end
  endtask

  task automatic test_reset_mid();
    int cyc, ar0, n; logic [31:0] rdat; logic err, pok;
    r_dly = 30; rdata_v = 32'h7777_0000; rresp_v = 2'b00;
    ar0 = ar_hs_tot;
    hs_ls4axim_val = 1; i_axim_adr = 32'h0000_0200; i_axim_wen = '0; i_axim_ren = 1;
    n = 0;
    while (ar_hs_tot == ar0 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk); @(negedge clk);
    checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL rstmid_in_rrsp got rready=%b want 1", m_rready); end
    rst = 1; hs_ls4axim_val = 0; i_axim_ren = 0;
    @(negedge clk);
    checks++;
    if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, hs_axim4ls_rdy} !== 6'b0) begin
      errors++; $display("FAIL rstmid_handshakes got %b want 000000",
                         {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, hs_axim4ls_rdy});
    end
    checks++;
    if ({o_axim_rdat, o_axim_err, o_bus_err_sticky} !== 34'h0) begin
      errors++; $display("FAIL rstmid_outputs got %h/%b/%b want 0/0/0", o_axim_rdat, o_axim_err, o_bus_err_sticky);
    end
    @(negedge clk);
    rst = 0; r_dly = 0; rdata_v = 32'h5A5A_A5A5;
    do_req(32'h0000_0208, 32'h0, 4'h0, 1'b1, cyc, rdat, err, pok);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL rstmid_fresh_latency got %0d want 3", cyc); end
    checks++; if ({rdat, err} !== {32'h5A5A_A5A5, 1'b0}) begin
      errors++; $display("FAIL rstmid_fresh_result got %h/%b want 5a5aa5a5/0", rdat, err);
    end
  endtask

`ifdef CIRNO9_AXIL_POSTWR_EN
  task automatic test_posted();
    int cyc, arb0; logic [31:0] rdat; logic err, pok;
    checks++; if (o_bus_err_sticky !== 1'b0) begin errors++; $display("FAIL post_sticky_init got 1 want 0"); end
    aw_dly = 0; w_dly = 0; b_dly = 10; bresp_v = 2'b11; r_dly = 0;
    rdata_v = 32'h0123_4567; rresp_v = 2'b00;
    arb0 = ar_during_b;
    do_req(32'h0000_0300, 32'hDEAD_0000, 4'b1100, 1'b0, cyc, rdat, err, pok);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL post_write_latency got %0d want 2", cyc); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL post_write_err got %b want 0", err); end
    do_req(32'h0000_0304, 32'h0, 4'h0, 1'b1, cyc, rdat, err, pok);
    checks++; if (cyc <= 3 || cyc >= 300) begin errors++; $display("FAIL post_read_held got %0d want 4..299", cyc); end
    checks++; if (ar_during_b !== arb0) begin errors++; $display("FAIL post_ar_before_b got %0d want 0", ar_during_b - arb0); end
    checks++; if ({rdat, err} !== {32'h0123_4567, 1'b0}) begin
      errors++; $display("FAIL post_read_result got %h/%b want 01234567/0", rdat, err);
    end
    checks++; if (o_bus_err_sticky !== 1'b1) begin errors++; $display("FAIL post_sticky_set got 0 want 1"); end
    b_dly = 0;
    do_req(32'h0000_0308, 32'h0, 4'h0, 1'b1, cyc, rdat, err, pok);
    checks++; if (o_bus_err_sticky !== 1'b1) begin errors++; $display("FAIL post_sticky_hold got 0 want 1"); end
  endtask
`endif

  task automatic test_random();
    int cyc, kind, n, aw0, ar0, any0;
    logic [31:0] adr, wd, rdat, exp_rdat;
    logic [3:0] wen;
    logic ren, err, exp_err, pok, exp_sticky;
    exp_rdat = '0; exp_sticky = 1'b0;
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while ((b_pend || r_pend || m_bvalid || m_rvalid) && n < 100) begin @(negedge clk); n++; end
      kind = (i == 0) ? 1 : int'($urandom_range(0, 4));
      adr = $urandom; wd = $urandom;
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 4);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 4);
      bresp_v = 2'($urandom); rresp_v = 2'($urandom); rdata_v = $urandom;
      wen = (kind == 0 || kind == 2) ? 4'($urandom_range(1, 15)) : 4'h0;
      ren = (kind == 1 || kind == 2 || kind == 3);
      if (wen != 4'h0) begin
`ifdef CIRNO9_AXIL_POSTWR_EN
        exp_err = 1'b0;
        if (bresp_v != 2'b00) exp_sticky = 1'b1;
`else
        exp_err = (bresp_v != 2'b00);
`endif
      end else if (ren) begin
        exp_err = (rresp_v != 2'b00); exp_rdat = rdata_v;
      end else begin
        exp_err = 1'b0; exp_rdat = '0;
      end
      aw0 = aw_hs_tot; ar0 = ar_hs_tot; any0 = anyv_tot;
      do_req(adr, wd, wen, ren, cyc, rdat, err, pok);
      checks++;
      if (cyc >= 300 || !pok) begin errors++; $display("FAIL rnd%0d_handshake cyc=%0d pulse=%b want <300/1", i, cyc, pok); end
      checks++;
      if ({rdat, err} !== {exp_rdat, exp_err}) begin
        errors++; $display("FAIL rnd%0d_result got %h/%b want %h/%b", i, rdat, err, exp_rdat, exp_err);
      end
      checks++;
      if (wen != 4'h0) begin
        if ({cap_awaddr, cap_wdata, cap_wstrb, aw_hs_tot - aw0} !== {adr & 32'hFFFF_FFFC, wd, wen, 32'd1}) begin
          errors++; $display("FAIL rnd%0d_write_bus got %h %h %b want %h %h %b", i,
                             cap_awaddr, cap_wdata, cap_wstrb, adr & 32'hFFFF_FFFC, wd, wen);
        end
      end else if (ren) begin
        if ({cap_araddr, ar_hs_tot - ar0} !== {adr & 32'hFFFF_FFFC, 32'd1}) begin
          errors++; $display("FAIL rnd%0d_read_bus got %h want %h", i, cap_araddr, adr & 32'hFFFF_FFFC);
        end
      end else if (anyv_tot !== any0) begin
        errors++; $display("FAIL rnd%0d_null_bus got %0d valid cycles want 0", i, anyv_tot - any0);
      end
    end
    n = 0;
    while ((b_pend || m_bvalid) && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++;
    if (o_bus_err_sticky !== exp_sticky) begin
      errors++; $display("FAIL rnd_sticky got %b want %b", o_bus_err_sticky, exp_sticky);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_rd_err();
    test_null();
    test_reset_mid();
`ifdef CIRNO9_AXIL_POSTWR_EN
    test_posted();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
